// File: rtl/fifo_drain_rr_arbiter.sv
// Drains NUM_SRC head-of-FIFO ports into a single registered output slot.
// Burst-limited round-robin: a source may keep the grant for up to MAX_BURST
// consecutive pops while it stays valid, then the search rotates past it.
module fifo_drain_rr_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]              src_pop,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_SRC)-1:0]      out_id,
  input  logic                            out_ready
);

  localparam int unsigned ID_W = $clog2(NUM_SRC);
  localparam int unsigned SumW = ID_W + 1;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  localparam logic [SumW-1:0] NumSrcW = SumW'(NUM_SRC);
  localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_SRC - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_BURST);

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       last_src_q, last_src_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;

  logic            slot_free;
  logic            hold;
  logic            arb_found;
  logic [ID_W-1:0] arb_idx;
  logic [ID_W-1:0] pick_idx;
  logic            pop;

  assign slot_free = ~out_valid_q | out_ready;

  // Continue the current burst while the last source stays valid and has budget left.
  assign hold = (burst_cnt_q != '0) && src_valid[last_src_q] && (burst_cnt_q < MaxCnt);

  // Round-robin search: first valid source at or after rr_ptr, modulo NUM_SRC.
  always_comb begin
    logic [SumW-1:0] sum;
    arb_found = 1'b0;
    arb_idx   = '0;
    sum       = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      sum = {1'b0, rr_ptr_q} + SumW'(k);
      if (sum >= NumSrcW) begin
        sum = sum - NumSrcW;
      end
      if (!arb_found && src_valid[sum[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = sum[ID_W-1:0];
      end
    end
  end

  assign pick_idx = hold ? last_src_q : arb_idx;

  // Gated by rst_n so no FIFO is popped while the block is held in reset.
  assign pop = rst_n & slot_free & (hold | arb_found);

  // One-hot pop decode of the chosen source.
  always_comb begin
    src_pop = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_pop[i] = pop && (pick_idx == ID_W'(i));
    end
  end

  // Output slot and arbitration next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    last_src_d  = last_src_q;
    burst_cnt_d = burst_cnt_q;

    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = src_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
      out_id_d    = pick_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (pop) begin
      if (hold) begin
        burst_cnt_d = burst_cnt_q + CntW'(1);
      end else begin
        burst_cnt_d = CntW'(1);
        last_src_d  = pick_idx;
        rr_ptr_d    = (pick_idx == LastIdx) ? '0 : pick_idx + ID_W'(1);
      end
    end else if (slot_free && !hold && (burst_cnt_q != '0)) begin
      // Burst ended (budget spent or source ran dry) with nothing else to pop:
      // forget it so a returning source must win arbitration again.
      burst_cnt_d = '0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      last_src_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      last_src_q  <= last_src_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_fifo_drain_rr_arbiter.sv
// Directed bench for fifo_drain_rr_arbiter: three instances cover the default
// burst policy, pure round-robin and a non-power-of-2 source count.
module tb_fifo_drain_rr_arbiter;

  logic clk;
  logic rst_a;
  logic rst_bc;

  // Instance A: NUM_SRC=4, MAX_BURST=4
  logic [3:0]   valid_a;
  logic [127:0] data_a;
  logic [3:0]   pop_a;
  logic         ovalid_a;
  logic [31:0]  odata_a;
  logic [1:0]   oid_a;
  logic         ready_a;

  // Instance B: NUM_SRC=4, MAX_BURST=1
  logic [3:0]   valid_b;
  logic [127:0] data_b;
  logic [3:0]   pop_b;
  logic         ovalid_b;
  logic [31:0]  odata_b;
  logic [1:0]   oid_b;
  logic         ready_b;

  // Instance C: NUM_SRC=3, MAX_BURST=1, 8-bit data
  logic [2:0]   valid_c;
  logic [23:0]  data_c;
  logic [2:0]   pop_c;
  logic         ovalid_c;
  logic [7:0]   odata_c;
  logic [1:0]   oid_c;
  logic         ready_c;

  int checks;
  int failures;

  fifo_drain_rr_arbiter #(.NUM_SRC(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .src_valid(valid_a), .src_data(data_a), .src_pop(pop_a),
    .out_valid(ovalid_a), .out_data(odata_a), .out_id(oid_a), .out_ready(ready_a)
  );

  fifo_drain_rr_arbiter #(.NUM_SRC(4), .DATA_WIDTH(32), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_bc), .src_valid(valid_b), .src_data(data_b), .src_pop(pop_b),
    .out_valid(ovalid_b), .out_data(odata_b), .out_id(oid_b), .out_ready(ready_b)
  );

  fifo_drain_rr_arbiter #(.NUM_SRC(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut_c (
    .clk(clk), .rst_n(rst_bc), .src_valid(valid_c), .src_data(data_c), .src_pop(pop_c),
    .out_valid(ovalid_c), .out_data(odata_c), .out_id(oid_c), .out_ready(ready_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hang guard
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int id;
    logic [3:0] exp_pop;
    checks   = 0;
    failures = 0;
    rst_a    = 1'b0;
    rst_bc   = 1'b0;
    valid_a  = 4'hF;
    data_a   = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hD0D0_0000};
    ready_a  = 1'b1;
    valid_b  = 4'h0;
    data_b   = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};
    ready_b  = 1'b1;
    valid_c  = 3'b000;
    data_c   = {8'hC2, 8'hC1, 8'hC0};
    ready_c  = 1'b1;

    // Reset state, with sources valid to confirm no pop during reset
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(ovalid_a), 64'd0);
    chk("rst_out_id", 64'(oid_a), 64'd0);
    chk("rst_out_data", 64'(odata_a), 64'd0);
    chk("rst_src_pop", 64'(pop_a), 64'd0);
    chk("rst_out_valid_b", 64'(ovalid_b), 64'd0);
    chk("rst_out_valid_c", 64'(ovalid_c), 64'd0);

    // Burst of 4 per source, all valid, consumer always ready
    rst_a  = 1'b1;
    rst_bc = 1'b1;
    #1;
    chk("burst_first_pop", 64'(pop_a), 64'b0001);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      id = (k / 4) % 4;
      exp_pop = 4'b0001 << (((k + 1) / 4) % 4);
      chk("burst_out_valid", 64'(ovalid_a), 64'd1);
      chk("burst_out_id", 64'(oid_a), 64'(id));
      chk("burst_out_data", 64'(odata_a), 64'(data_a[id*32 +: 32]));
      chk("burst_src_pop", 64'(pop_a), 64'(exp_pop));
    end

    // Asynchronous reset mid-stream
    #2;
    rst_a = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ovalid_a), 64'd0);
    chk("midrst_src_pop", 64'(pop_a), 64'd0);
    chk("midrst_out_data", 64'(odata_a), 64'd0);
    chk("midrst_out_id", 64'(oid_a), 64'd0);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("postrst_src_pop", 64'(pop_a), 64'b0001);
    @(negedge clk);
    chk("postrst_out_valid", 64'(ovalid_a), 64'd1);
    chk("postrst_out_id", 64'(oid_a), 64'd0);
    chk("postrst_out_data", 64'(odata_a), 64'hD0D0_0000);

    // Backpressure: 5 stalled cycles, FIFO head of source 0 moves to a new word
    ready_a = 1'b0;
    data_a[31:0] = 32'hD0D0_0001;
    #1;
    chk("stall_src_pop0", 64'(pop_a), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(ovalid_a), 64'd1);
      chk("stall_out_id", 64'(oid_a), 64'd0);
      chk("stall_out_data", 64'(odata_a), 64'hD0D0_0000);
      chk("stall_src_pop", 64'(pop_a), 64'd0);
    end
    ready_a = 1'b1;
    #1;
    chk("unstall_src_pop", 64'(pop_a), 64'b0001);
    @(negedge clk);
    chk("unstall_out_valid", 64'(ovalid_a), 64'd1);
    chk("unstall_out_data", 64'(odata_a), 64'hD0D0_0001);
    chk("unstall_out_id", 64'(oid_a), 64'd0);

    // Early burst end: source 2 holds two words, source 0 joins later
    rst_a   = 1'b0;
    valid_a = 4'b0100;
    data_a[95:64] = 32'h2222_0010;
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("early_pop1", 64'(pop_a), 64'b0100);
    @(negedge clk);
    chk("early_id1", 64'(oid_a), 64'd2);
    chk("early_data1", 64'(odata_a), 64'h2222_0010);
    valid_a = 4'b0101;
    data_a[95:64] = 32'h2222_0011;
    #1;
    chk("early_pop2_hold", 64'(pop_a), 64'b0100);
    @(negedge clk);
    chk("early_id2", 64'(oid_a), 64'd2);
    chk("early_data2", 64'(odata_a), 64'h2222_0011);
    valid_a = 4'b0001;
    #1;
    chk("early_pop3", 64'(pop_a), 64'b0001);
    @(negedge clk);
    chk("early_id3", 64'(oid_a), 64'd0);
    chk("early_valid3", 64'(ovalid_a), 64'd1);
    valid_a = 4'b0000;
    #1;
    chk("idle_src_pop", 64'(pop_a), 64'd0);
    @(negedge clk);
    chk("drain_out_valid", 64'(ovalid_a), 64'd0);

    // Pure round-robin with sources 1 and 3
    valid_b = 4'b1010;
    #1;
    chk("rr_first_pop", 64'(pop_b), 64'b0010);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_out_valid", 64'(ovalid_b), 64'd1);
      chk("rr_out_id", 64'(oid_b), (k % 2 == 0) ? 64'd1 : 64'd3);
      chk("rr_no_pop_0_2", 64'(pop_b & 4'b0101), 64'd0);
      chk("rr_src_pop", 64'(pop_b), (k % 2 == 0) ? 64'b1000 : 64'b0010);
    end
    valid_b = 4'b0000;

    // Three sources: steer rr_ptr to 2, then only source 0 valid
    valid_c = 3'b111;
    #1;
    chk("wrap_pop_a", 64'(pop_c), 64'b001);
    @(negedge clk);
    chk("wrap_id_a", 64'(oid_c), 64'd0);
    chk("wrap_pop_b", 64'(pop_c), 64'b010);
    @(negedge clk);
    chk("wrap_id_b", 64'(oid_c), 64'd1);
    chk("wrap_rr_before", 64'(dut_c.rr_ptr_q), 64'd2);
    valid_c = 3'b001;
    #1;
    chk("wrap_pop_0", 64'(pop_c), 64'b001);
    @(negedge clk);
    chk("wrap_id_0", 64'(oid_c), 64'd0);
    chk("wrap_data_0", 64'(odata_c), 64'hC0);
    chk("wrap_rr_after", 64'(dut_c.rr_ptr_q), 64'd1);
    valid_c = 3'b000;

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
